// File: rtl/exec_sequencer_if.sv
// Bus between the instruction memory / control unit side and the program sequencer.
// The sequencer side uses the slave modport; the driving side uses master.
interface exec_sequencer_if #(
  parameter int PC_W     = 4,
  parameter int OPCODE_W = 7,
  parameter int CNT_W    = 8
);
  logic                start;
  logic                step_mode;
  logic [OPCODE_W-1:0] opcode;
  logic                cu_regA_load;
  logic                cu_regB_load;
  logic [PC_W-1:0]     pc;
  logic                regA_load;
  logic                regB_load;
  logic                busy;
  logic                halted;
  logic [CNT_W-1:0]    instr_count;

  modport master (
    output start, step_mode, opcode, cu_regA_load, cu_regB_load,
    input  pc, regA_load, regB_load, busy, halted, instr_count
  );

  modport slave (
    input  start, step_mode, opcode, cu_regA_load, cu_regB_load,
    output pc, regA_load, regB_load, busy, halted, instr_count
  );
endinterface

// File: rtl/exec_sequencer.sv
// FETCH/DECODE/EXEC program sequencer: owns the PC, gates register loads to the
// execute cycle, and provides start / single-step / sticky halt control.
module exec_sequencer #(
  parameter int                  PC_W        = 4,
  parameter int                  OPCODE_W    = 7,
  parameter logic [OPCODE_W-1:0] HALT_OPCODE = 7'h7F,
  parameter int                  CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  exec_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALT   = 3'd4
  } state_t;

  state_t           state_q;
  state_t           state_nxt;
  logic [PC_W-1:0]  pc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rega_ld;
  logic             regb_ld;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      if (state_q == EXEC) begin
        pc_q  <= pc_q + PC_W'(1);
        cnt_q <= sat_inc(cnt_q);
      end
    end
  end

  always_comb begin
    state_nxt = state_q;
    rega_ld   = 1'b0;
    regb_ld   = 1'b0;
    case (state_q)
      IDLE:   if (bus.start) state_nxt = FETCH;
      FETCH:  state_nxt = DECODE;
      DECODE: state_nxt = (bus.opcode == HALT_OPCODE) ? HALT : EXEC;
      EXEC: begin
        // Datapath registers have no reset, so loads must die with rst_n.
        rega_ld   = bus.cu_regA_load & rst_n;
        regb_ld   = bus.cu_regB_load & rst_n;
        state_nxt = bus.step_mode ? IDLE : FETCH;
      end
      HALT:   state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.pc          = pc_q;
  assign bus.instr_count = cnt_q;
  assign bus.regA_load   = rega_ld;
  assign bus.regB_load   = regb_ld;
  assign bus.busy        = (state_q == FETCH) || (state_q == DECODE) || (state_q == EXEC);
  assign bus.halted      = (state_q == HALT);

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: reset, run-to-halt, step mode, pc wrap,
// reset during execute and retired-count saturation.
module tb_exec_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  logic [6:0] prog_op [16];
  logic       prog_a  [16];
  logic       prog_b  [16];

  exec_sequencer_if #(.PC_W(4), .OPCODE_W(7), .CNT_W(8)) bus ();

  exec_sequencer #(
    .PC_W(4), .OPCODE_W(7), .HALT_OPCODE(7'h7F), .CNT_W(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.opcode       = prog_op[bus.pc];
  assign bus.cu_regA_load = prog_a[bus.pc];
  assign bus.cu_regB_load = prog_b[bus.pc];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load_plain_prog();
    for (int i = 0; i < 16; i++) begin
      prog_op[i] = 7'(8'h10 + i);
      prog_a[i]  = 1'b0;
      prog_b[i]  = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    load_plain_prog();
    prog_a[0] = 1'b1;
    prog_b[0] = 1'b1;
    rst_n = 1'b0;
    bus.start = 1'b1;
    bus.step_mode = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    total++; if (bus.pc !== 4'd0) begin bad++; $display("FAIL reset_pc got=%0h want=0", bus.pc); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b want=0", bus.halted); end
    total++; if (bus.regA_load !== 1'b0) begin bad++; $display("FAIL reset_regA_load got=%b want=0", bus.regA_load); end
    total++; if (bus.regB_load !== 1'b0) begin bad++; $display("FAIL reset_regB_load got=%b want=0", bus.regB_load); end
    total++; if (bus.instr_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.instr_count); end
    next_cycle();
    rst_n = 1'b1;
    bus.start = 1'b0;
    next_cycle();
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_idle_hold got=%b want=0", bus.busy); end
  endtask

  task automatic test_run_to_halt();
    logic exp_a, exp_b, exp_busy, exp_halt;
    load_plain_prog();
    prog_a[0]  = 1'b1;
    prog_b[1]  = 1'b1;
    prog_op[3] = 7'h7F;
    bus.step_mode = 1'b0;
    do_reset();
    bus.start = 1'b1;
    for (int c = 0; c <= 13; c++) begin
      exp_a    = (c == 3);
      exp_b    = (c == 6);
      exp_busy = (c >= 1) && (c <= 11);
      exp_halt = (c >= 12);
      @(negedge clk);
      total++; if (bus.regA_load !== exp_a) begin bad++; $display("FAIL run_regA_load c=%0d got=%b want=%b", c, bus.regA_load, exp_a); end
      total++; if (bus.regB_load !== exp_b) begin bad++; $display("FAIL run_regB_load c=%0d got=%b want=%b", c, bus.regB_load, exp_b); end
      total++; if (bus.busy !== exp_busy) begin bad++; $display("FAIL run_busy c=%0d got=%b want=%b", c, bus.busy, exp_busy); end
      total++; if (bus.halted !== exp_halt) begin bad++; $display("FAIL run_halted c=%0d got=%b want=%b", c, bus.halted, exp_halt); end
      next_cycle();
      bus.start = 1'b0;
    end
    total++; if (bus.pc !== 4'd3) begin bad++; $display("FAIL run_final_pc got=%0d want=3", bus.pc); end
    total++; if (bus.instr_count !== 8'd3) begin bad++; $display("FAIL run_final_count got=%0d want=3", bus.instr_count); end
    // Start while halted must be ignored.
    bus.start = 1'b1;
    next_cycle();
    bus.start = 1'b0;
    for (int c = 0; c < 4; c++) next_cycle();
    @(negedge clk);
    total++; if (bus.halted !== 1'b1) begin bad++; $display("FAIL halt_sticky got=%b want=1", bus.halted); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL halt_busy got=%b want=0", bus.busy); end
    total++; if (bus.pc !== 4'd3) begin bad++; $display("FAIL halt_pc got=%0d want=3", bus.pc); end
  endtask

  task automatic test_step_mode();
    logic exp_busy;
    load_plain_prog();
    bus.step_mode = 1'b1;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      bus.start = 1'b1;
      for (int c = 0; c < 6; c++) begin
        exp_busy = (c >= 1) && (c <= 3);
        @(negedge clk);
        total++; if (bus.busy !== exp_busy) begin bad++; $display("FAIL step_busy p=%0d c=%0d got=%b want=%b", p, c, bus.busy, exp_busy); end
        next_cycle();
        // Raise start during DECODE; it must not cause an extra step.
        bus.start = (c == 1);
      end
      total++; if (bus.pc !== 4'(p + 1)) begin bad++; $display("FAIL step_pc p=%0d got=%0d want=%0d", p, bus.pc, p + 1); end
      total++; if (bus.instr_count !== 8'(p + 1)) begin bad++; $display("FAIL step_count p=%0d got=%0d want=%0d", p, bus.instr_count, p + 1); end
    end
    bus.step_mode = 1'b0;
  endtask

  task automatic test_wrap();
    load_plain_prog();
    bus.step_mode = 1'b0;
    do_reset();
    bus.start = 1'b1;
    for (int c = 0; c <= 52; c++) begin
      @(negedge clk);
      if (c == 46) begin
        total++; if (bus.pc !== 4'd15) begin bad++; $display("FAIL wrap_pc15 got=%0d want=15", bus.pc); end
      end
      if (c == 49) begin
        total++; if (bus.pc !== 4'd0) begin bad++; $display("FAIL wrap_pc0 got=%0d want=0", bus.pc); end
      end
      if (c == 52) begin
        total++; if (bus.pc !== 4'd1) begin bad++; $display("FAIL wrap_pc1 got=%0d want=1", bus.pc); end
        total++; if (bus.instr_count !== 8'd17) begin bad++; $display("FAIL wrap_count got=%0d want=17", bus.instr_count); end
        total++; if (bus.halted !== 1'b0) begin bad++; $display("FAIL wrap_halted got=%b want=0", bus.halted); end
      end
      next_cycle();
      bus.start = 1'b0;
    end
  endtask

  task automatic test_reset_mid_exec();
    load_plain_prog();
    prog_a[0] = 1'b1;
    prog_a[1] = 1'b1;
    prog_b[1] = 1'b1;
    bus.step_mode = 1'b0;
    do_reset();
    bus.start = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (c == 3) begin
        total++; if (bus.regA_load !== 1'b1) begin bad++; $display("FAIL midexec_first_load got=%b want=1", bus.regA_load); end
      end
      next_cycle();
      bus.start = 1'b0;
    end
    // Cycle 6 is the EXEC of the second instruction.
    rst_n = 1'b0;
    #1;
    total++; if (bus.regA_load !== 1'b0) begin bad++; $display("FAIL midexec_regA_load got=%b want=0", bus.regA_load); end
    total++; if (bus.regB_load !== 1'b0) begin bad++; $display("FAIL midexec_regB_load got=%b want=0", bus.regB_load); end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midexec_busy got=%b want=0", bus.busy); end
    total++; if (bus.pc !== 4'd0) begin bad++; $display("FAIL midexec_pc got=%0d want=0", bus.pc); end
    total++; if (bus.instr_count !== 8'd0) begin bad++; $display("FAIL midexec_count got=%0d want=0", bus.instr_count); end
    total++; if (bus.halted !== 1'b0) begin bad++; $display("FAIL midexec_halted got=%b want=0", bus.halted); end
  endtask

  task automatic test_saturation();
    load_plain_prog();
    bus.step_mode = 1'b0;
    do_reset();
    bus.start = 1'b1;
    for (int c = 0; c <= 901; c++) begin
      @(negedge clk);
      if (c == 763) begin
        total++; if (bus.instr_count !== 8'd254) begin bad++; $display("FAIL sat_254 got=%0d want=254", bus.instr_count); end
      end
      if (c == 766) begin
        total++; if (bus.instr_count !== 8'd255) begin bad++; $display("FAIL sat_255 got=%0d want=255", bus.instr_count); end
      end
      if (c == 901) begin
        total++; if (bus.instr_count !== 8'd255) begin bad++; $display("FAIL sat_hold got=%0d want=255", bus.instr_count); end
        total++; if (bus.pc !== 4'd12) begin bad++; $display("FAIL sat_pc got=%0d want=12", bus.pc); end
      end
      next_cycle();
      bus.start = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.step_mode = 1'b0;
    test_reset();
    test_run_to_halt();
    test_step_mode();
    test_wrap();
    test_reset_mid_exec();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
